// File: rtl/cpu_pkg.sv
// Shared opcodes, phase encoding and control-strobe bundle for the RISC CPU controller.
package cpu_pkg;
  localparam int OPCODE_WIDTH = 3;
  localparam int PHASE_WIDTH  = 3;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 3'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_SKZ = 3'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 3'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = 3'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = 3'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 3'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO = 3'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 3'd7;

  typedef enum logic [PHASE_WIDTH-1:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic wr;
    logic ld_ir;
    logic ld_ac;
    logic ld_pc;
    logic inc_pc;
    logic data_e;
    logic halt;
  } ctrl_t;

  // Opcodes that read an operand from memory into the ALU/accumulator.
  function automatic logic is_aluop(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction
endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe decode from (phase, opcode, zero, halted).
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  phase_e                  phase,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
  input  logic                    halted,
  output ctrl_t                   ctrl
);
  logic aluop;
  assign aluop = is_aluop(opcode);

  always_comb begin
    ctrl = '0;
    if (halted) begin
      ctrl.sel  = 1'b1;
      ctrl.halt = 1'b1;
    end else begin
      case (phase)
        PH_INST_ADDR:  ctrl.sel = 1'b1;
        PH_INST_FETCH: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          ctrl.inc_pc = 1'b1;
          ctrl.halt   = (opcode == OP_HLT);
        end
        PH_OP_FETCH: ctrl.rd = aluop;
        PH_ALU_OP: begin
          ctrl.rd     = aluop;
          ctrl.inc_pc = (opcode == OP_SKZ) && zero;
          ctrl.ld_pc  = (opcode == OP_JMP);
          ctrl.data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          ctrl.rd     = aluop;
          ctrl.ld_ac  = aluop;
          ctrl.inc_pc = (opcode == OP_JMP);
          ctrl.ld_pc  = (opcode == OP_JMP);
          ctrl.wr     = (opcode == OP_STO);
          ctrl.data_e = (opcode == OP_STO);
        end
        default: ctrl = '0;
      endcase
    end
  end
endmodule

// File: rtl/cpu_controller.sv
// 8-phase fetch/execute sequencer with sticky halt.
// Optional CPU_CTRL_SINGLE_STEP_EN adds step_mode/step to gate each instruction.
module cpu_controller #(
  parameter int OPCODE_WIDTH = cpu_pkg::OPCODE_WIDTH,
  parameter int PHASE_WIDTH  = cpu_pkg::PHASE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    zero,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic                    step_mode,
  input  logic                    step,
`endif
  output logic                    sel,
  output logic                    rd,
  output logic                    wr,
  output logic                    ld_ir,
  output logic                    ld_ac,
  output logic                    ld_pc,
  output logic                    inc_pc,
  output logic                    data_e,
  output logic                    halt,
  output logic [PHASE_WIDTH-1:0]  phase
);
  import cpu_pkg::phase_e;
  import cpu_pkg::ctrl_t;
  import cpu_pkg::PH_INST_ADDR;
  import cpu_pkg::PH_OP_ADDR;
  import cpu_pkg::OP_HLT;

  phase_e ph_q, ph_d;
  logic   halted_q, halted_d;
  logic   hold;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q     <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      halted_q <= halted_d;
    end
  end

`ifdef CPU_CTRL_SINGLE_STEP_EN
  // Park at INST_ADDR until a step pulse releases one full instruction.
  assign hold = step_mode && (ph_q == PH_INST_ADDR) && !step;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    ph_d     = ph_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if ((ph_q == PH_OP_ADDR) && (opcode == OP_HLT)) halted_d = 1'b1;
      if (!hold) ph_d = phase_e'(ph_q + 3'd1);
    end
  end

  cpu_ctrl_decode u_decode (
    .phase  (ph_q),
    .opcode (opcode),
    .zero   (zero),
    .halted (halted_q),
    .ctrl   (ctrl)
  );

  assign sel    = ctrl.sel;
  assign rd     = ctrl.rd;
  assign wr     = ctrl.wr;
  assign ld_ir  = ctrl.ld_ir;
  assign ld_ac  = ctrl.ld_ac;
  assign ld_pc  = ctrl.ld_pc;
  assign inc_pc = ctrl.inc_pc;
  assign data_e = ctrl.data_e;
  assign halt   = ctrl.halt;
  assign phase  = PHASE_WIDTH'(ph_q);
endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: fixed vector table, random run vs. a
// behavioural model, and hand-written halt / async-reset / single-step sequences.
module tb_cpu_controller;
  logic       clk, rst, zero;
  logic [2:0] opcode;
  logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic [2:0] phase;
`ifdef CPU_CTRL_SINGLE_STEP_EN
  logic       step_mode, step;
`endif

  cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac), .ld_pc(ld_pc),
    .inc_pc(inc_pc), .data_e(data_e), .halt(halt), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
  logic [8:0] outs;
  assign outs = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};

  int vectors = 0;
  int miscompares = 0;
  int m_ph = 0;
  bit m_halt = 1'b0;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [2:0] ph;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];

  // Expected strobes derived straight from the per-phase rules.
  function automatic logic [8:0] model_exp(int ph, bit hlt, logic [2:0] op, logic z);
    bit alu, s, r, w, li, la, lp, ip, de, h;
    if (hlt) return 9'b100000001;
    alu = (op >= 3'd2) && (op <= 3'd5);
    s   = ph < 4;
    r   = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    w   = (ph == 7) && (op == 3'd6);
    li  = (ph == 2) || (ph == 3);
    la  = (ph == 7) && alu;
    lp  = (ph >= 6) && (op == 3'd7);
    ip  = (ph == 4) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
    de  = (ph >= 6) && (op == 3'd6);
    h   = (ph == 4) && (op == 3'd0);
    return {s, r, w, li, la, lp, ip, de, h};
  endfunction

  task automatic chk(input string nm, input logic [2:0] eph, input logic [8:0] eexp);
    vectors++;
    if (phase !== eph || outs !== eexp) begin
      miscompares++;
      $display("FAIL %s: got phase=%0d outs=%b, want phase=%0d outs=%b",
               nm, phase, outs, eph, eexp);
    end
  endtask

  // Bench sits just after a negedge; cyc drives inputs and settles,
  // nxt advances the model and moves to the following negedge.
  task automatic cyc(input logic [2:0] op, input logic z);
    opcode = op;
    zero   = z;
    #1;
  endtask

  task automatic nxt();
    bit hold;
    hold = 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    hold = step_mode && (m_ph == 0) && !step;
`endif
    if (!m_halt) begin
      if (m_ph == 4 && opcode == 3'd0) m_halt = 1'b1;
      if (!hold) m_ph = (m_ph + 1) % 8;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    opcode = 3'd0;
    #1;
    chk("reset", 3'd0, 9'b100000000);
    #1;
    rst = 1'b0;
    m_ph = 0;
    m_halt = 1'b0;
  endtask

  logic [2:0] sc_op [5] = '{3'd2, 3'd6, 3'd7, 3'd1, 3'd1};
  logic       sc_z  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [8:0] head  [4] = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000};
  logic [8:0] tail  [5][4] = '{
    '{9'b000000100, 9'b010000000, 9'b010000000, 9'b010010000},  // ADD
    '{9'b000000100, 9'b000000000, 9'b000000010, 9'b001000010},  // STO
    '{9'b000000100, 9'b000000000, 9'b000001000, 9'b000001100},  // JMP
    '{9'b000000100, 9'b000000000, 9'b000000100, 9'b000000000},  // SKZ, zero=1
    '{9'b000000100, 9'b000000000, 9'b000000000, 9'b000000000}   // SKZ, zero=0
  };

  initial begin
    vec_t v;
    rst = 1'b1;
    opcode = 3'd0;
    zero = 1'b0;
`ifdef CPU_CTRL_SINGLE_STEP_EN
    step_mode = 1'b0;
    step = 1'b0;
`endif
    for (int s = 0; s < 5; s++)
      for (int p = 0; p < 8; p++) begin
        v.op  = sc_op[s];
        v.z   = sc_z[s];
        v.ph  = 3'(p);
        v.exp = (p < 4) ? head[p] : tail[s][p-4];
        tbl.push_back(v);
      end

    @(negedge clk);
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].op, tbl[i].z);
      chk($sformatf("tbl[%0d]", i), tbl[i].ph, tbl[i].exp);
      nxt();
    end

    for (int i = 0; i < 300; i++) begin
      cyc(3'($urandom_range(1, 7)), 1'($urandom_range(0, 1)));
      chk("rand", 3'(m_ph), model_exp(m_ph, m_halt, opcode, zero));
      nxt();
    end

    // Halt: enters at OP_ADDR, then frozen at OP_FETCH until reset.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      cyc(3'd2, 1'b0);
      chk("pre_hlt", 3'(p), model_exp(p, 1'b0, opcode, zero));
      nxt();
    end
    cyc(3'd0, 1'b0);
    chk("hlt_ph4", 3'd4, 9'b000000101);
    nxt();
    for (int i = 0; i < 20; i++) begin
      cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      chk("halted", 3'd5, 9'b100000001);
      nxt();
    end
    do_reset();
    cyc(3'd2, 1'b0);
    chk("post_hlt_rst", 3'd0, 9'b100000000);
    nxt();
    cyc(3'd2, 1'b0);
    chk("post_hlt_run", 3'd1, 9'b110000000);
    nxt();

    // Async reset in the middle of STORE with STO drops wr at once.
    do_reset();
    for (int p = 0; p < 7; p++) begin
      cyc(3'd6, 1'b0);
      nxt();
    end
    cyc(3'd6, 1'b0);
    chk("sto_ph7", 3'd7, 9'b001000010);
    rst = 1'b1;
    #1;
    chk("async_rst", 3'd0, 9'b100000000);
    #1;
    rst = 1'b0;
    m_ph = 0;
    m_halt = 1'b0;
    nxt();
    cyc(3'd6, 1'b0);
    chk("after_async", 3'd1, 9'b110000000);
    nxt();

`ifdef CPU_CTRL_SINGLE_STEP_EN
    do_reset();
    step_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(3'd2, 1'b0);
      chk("step_hold", 3'd0, model_exp(0, 1'b0, opcode, zero));
      nxt();
    end
    step = 1'b1;
    cyc(3'd2, 1'b0);
    chk("step_pulse", 3'd0, model_exp(0, 1'b0, opcode, zero));
    nxt();
    step = 1'b0;
    for (int p = 1; p < 8; p++) begin
      cyc(3'd2, 1'b0);
      chk("step_run", 3'(p), model_exp(p, 1'b0, opcode, zero));
      nxt();
    end
    for (int i = 0; i < 3; i++) begin
      cyc(3'd2, 1'b0);
      chk("step_rehold", 3'd0, model_exp(0, 1'b0, opcode, zero));
      nxt();
    end
    step_mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
